// File: rtl/frog_game_controller.sv
// Frogger player-token controller: move arbitration with cooldown, position, lives, score and round FSM.
// Optional horizontal wrap-around at the grid edges is enabled by defining FROG_WRAP_EN.
module frog_game_controller #(
  parameter int GRID_W        = 20,
  parameter int GRID_H        = 15,
  parameter int START_X       = 10,
  parameter int START_Y       = 14,
  parameter int LIVES         = 3,
  parameter int MOVE_COOLDOWN = 4,
  parameter int HOLD_CYCLES   = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] move_req,
  input  logic       start,
  input  logic       collision,
  output logic [4:0] x_pos,
  output logic [3:0] y_pos,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic [2:0] state,
  output logic       move_ack
);

  localparam int CD_W = $clog2(MOVE_COOLDOWN + 1);
  localparam int HD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [4:0]      X_MAX      = 5'(GRID_W - 1);
  localparam logic [4:0]      X_START    = 5'(START_X);
  localparam logic [3:0]      Y_MAX      = 4'(GRID_H - 1);
  localparam logic [3:0]      Y_START    = 4'(START_Y);
  localparam logic [1:0]      LIVES_INIT = 2'(LIVES);
  localparam logic [CD_W-1:0] CD_LOAD    = CD_W'(MOVE_COOLDOWN);
  localparam logic [CD_W-1:0] CD_ONE     = CD_W'(1);
  localparam logic [HD_W-1:0] HOLD_LOAD  = HD_W'(HOLD_CYCLES);
  localparam logic [HD_W-1:0] HOLD_ONE   = HD_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PLAY = 3'd1,
    ST_DEAD = 3'd2,
    ST_GOAL = 3'd3,
    ST_OVER = 3'd4
  } state_t;

  state_t          r_state, w_state;
  logic [4:0]      r_x, w_x;
  logic [3:0]      r_y, w_y;
  logic [1:0]      r_lives, w_lives;
  logic [7:0]      r_score, w_score;
  logic            r_ack, w_ack;
  logic [CD_W-1:0] r_cd, w_cd;
  logic [HD_W-1:0] r_hold, w_hold;
  logic [3:0]      w_win;

  // Isolate the lowest set request bit: up beats left beats right beats down.
  assign w_win = move_req & (~move_req + 4'd1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_x     <= X_START;
      r_y     <= Y_START;
      r_lives <= LIVES_INIT;
      r_score <= 8'd0;
      r_ack   <= 1'b0;
      r_cd    <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state;
      r_x     <= w_x;
      r_y     <= w_y;
      r_lives <= w_lives;
      r_score <= w_score;
      r_ack   <= w_ack;
      r_cd    <= w_cd;
      r_hold  <= w_hold;
    end
  end

  always_comb begin
    w_state = r_state;
    w_x     = r_x;
    w_y     = r_y;
    w_lives = r_lives;
    w_score = r_score;
    w_ack   = 1'b0;
    w_cd    = (r_cd != '0) ? (r_cd - CD_ONE) : '0;
    w_hold  = r_hold;

    case (r_state)
      ST_IDLE: begin
        if (start) w_state = ST_PLAY;
      end

      ST_PLAY: begin
        if (collision) begin
          if (r_lives != 2'd0) w_lives = r_lives - 2'd1;
          w_hold  = HOLD_LOAD;
          w_state = ST_DEAD;
        end else if ((w_win != 4'd0) && (r_cd == '0)) begin
          // Off-grid moves are still acknowledged and still start a cooldown.
          w_ack = 1'b1;
          w_cd  = CD_LOAD;
          if (w_win[0]) begin
            if (r_y != 4'd0) w_y = r_y - 4'd1;
            if (r_y == 4'd1) begin
              if (r_score != 8'hFF) w_score = r_score + 8'd1;
              w_hold  = HOLD_LOAD;
              w_state = ST_GOAL;
            end
          end else if (w_win[1]) begin
            if (r_x != 5'd0) w_x = r_x - 5'd1;
`ifdef FROG_WRAP_EN
            else w_x = X_MAX;
`endif
          end else if (w_win[2]) begin
            if (r_x != X_MAX) w_x = r_x + 5'd1;
`ifdef FROG_WRAP_EN
            else w_x = 5'd0;
`endif
          end else begin
            if (r_y != Y_MAX) w_y = r_y + 4'd1;
          end
        end
      end

      ST_DEAD, ST_GOAL: begin
        if (r_hold <= HOLD_ONE) begin
          w_hold = '0;
          w_x    = X_START;
          w_y    = Y_START;
          if ((r_state == ST_GOAL) || (r_lives != 2'd0)) begin
            w_cd    = '0;
            w_state = ST_PLAY;
          end else begin
            w_state = ST_OVER;
          end
        end else begin
          w_hold = r_hold - HOLD_ONE;
        end
      end

      ST_OVER: begin
        if (start) begin
          w_lives = LIVES_INIT;
          w_score = 8'd0;
          w_cd    = '0;
          w_state = ST_PLAY;
        end
      end

      default: w_state = ST_IDLE;
    endcase
  end

  assign x_pos    = r_x;
  assign y_pos    = r_y;
  assign lives    = r_lives;
  assign score    = r_score;
  assign state    = r_state;
  assign move_ack = r_ack;

endmodule

// File: tb/tb_frog_game_controller.sv
// Directed self-checking bench for frog_game_controller; expectations are hand-derived
// for the default parameters (10/14 start, 3 lives, cooldown 4, hold 8).
module tb_frog_game_controller;

  logic       clock;
  logic       reset_n;
  logic [3:0] move_req;
  logic       start;
  logic       collision;
  logic [4:0] x_pos;
  logic [3:0] y_pos;
  logic [1:0] lives;
  logic [7:0] score;
  logic [2:0] state;
  logic       move_ack;

  int checkCount = 0;
  int errorCount = 0;
  int expLeftEdge;

  frog_game_controller dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .move_req  (move_req),
    .start     (start),
    .collision (collision),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .lives     (lives),
    .score     (score),
    .state     (state),
    .move_ack  (move_ack)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Called at a falling edge; drives one rising edge with the given pulses, returns at the next falling edge.
  task automatic applyStimulus(input logic [3:0] req, input logic st, input logic col);
    move_req  = req;
    start     = st;
    collision = col;
    @(posedge clock);
    @(negedge clock);
    move_req  = 4'd0;
    start     = 1'b0;
    collision = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  // Fourteen spaced up moves from the start row; returns right after the goal-entering edge.
  task automatic doGoal();
    for (int i = 0; i < 14; i++) begin
      applyStimulus(4'b0001, 1'b0, 1'b0);
      if (i < 13) idleCycles(4);
    end
  endtask

  initial begin
`ifdef FROG_WRAP_EN
    expLeftEdge = 19;
`else
    expLeftEdge = 0;
`endif
    clock     = 1'b0;
    reset_n   = 1'b1;
    move_req  = 4'd0;
    start     = 1'b0;
    collision = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    checkOutput("reset_state", int'(state), 0);
    checkOutput("reset_x", int'(x_pos), 10);
    checkOutput("reset_y", int'(y_pos), 14);
    checkOutput("reset_lives", int'(lives), 3);
    checkOutput("reset_score", int'(score), 0);
    checkOutput("reset_ack", int'(move_ack), 0);
    @(negedge clock);
    reset_n = 1'b1;

    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("idle_ignores_move_y", int'(y_pos), 14);
    checkOutput("idle_ignores_move_state", int'(state), 0);

    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("start_state", int'(state), 1);

    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("first_up_y", int'(y_pos), 13);
    checkOutput("first_up_ack", int'(move_ack), 1);
    checkOutput("first_up_state", int'(state), 1);
    idleCycles(1);
    checkOutput("ack_one_cycle", int'(move_ack), 0);
    idleCycles(3);

    applyStimulus(4'b0111, 1'b0, 1'b0);
    checkOutput("priority_up_y", int'(y_pos), 12);
    checkOutput("priority_up_x", int'(x_pos), 10);
    checkOutput("priority_up_ack", int'(move_ack), 1);

    idleCycles(1);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("cooldown_drop_y", int'(y_pos), 12);
    checkOutput("cooldown_drop_ack", int'(move_ack), 0);

    idleCycles(2);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    checkOutput("cooldown_expiry_down_y", int'(y_pos), 13);
    checkOutput("cooldown_expiry_ack", int'(move_ack), 1);

    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("start_ignored_in_play", int'(state), 1);

    for (int i = 0; i < 10; i++) begin
      idleCycles(4);
      applyStimulus(4'b0010, 1'b0, 1'b0);
    end
    checkOutput("walk_left_x", int'(x_pos), 0);

    idleCycles(4);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    checkOutput("left_edge_x", int'(x_pos), expLeftEdge);
    checkOutput("left_edge_ack", int'(move_ack), 1);

    idleCycles(4);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    checkOutput("down_to_bottom_y", int'(y_pos), 14);
    idleCycles(4);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    checkOutput("bottom_edge_y", int'(y_pos), 14);
    checkOutput("bottom_edge_ack", int'(move_ack), 1);

    idleCycles(4);
    applyStimulus(4'b0001, 1'b0, 1'b1);
    checkOutput("collision_state", int'(state), 2);
    checkOutput("collision_lives", int'(lives), 2);
    checkOutput("collision_no_move_y", int'(y_pos), 14);
    checkOutput("collision_no_ack", int'(move_ack), 0);
    idleCycles(7);
    checkOutput("dead_dwell_state", int'(state), 2);
    idleCycles(1);
    checkOutput("respawn_state", int'(state), 1);
    checkOutput("respawn_x", int'(x_pos), 10);
    checkOutput("respawn_y", int'(y_pos), 14);

    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("second_death_lives", int'(lives), 1);
    idleCycles(8);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("third_death_lives", int'(lives), 0);
    idleCycles(8);
    checkOutput("game_over_state", int'(state), 4);
    checkOutput("game_over_x", int'(x_pos), 10);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("over_ignores_move_y", int'(y_pos), 14);

    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("restart_state", int'(state), 1);
    checkOutput("restart_lives", int'(lives), 3);
    checkOutput("restart_score", int'(score), 0);

    doGoal();
    checkOutput("goal_state", int'(state), 3);
    checkOutput("goal_score", int'(score), 1);
    checkOutput("goal_y", int'(y_pos), 0);
    idleCycles(7);
    checkOutput("goal_dwell_state", int'(state), 3);
    idleCycles(1);
    checkOutput("goal_respawn_state", int'(state), 1);
    checkOutput("goal_respawn_y", int'(y_pos), 14);
    checkOutput("goal_keeps_lives", int'(lives), 3);

    for (int g = 0; g < 254; g++) begin
      doGoal();
      idleCycles(8);
    end
    checkOutput("score_reaches_255", int'(score), 255);
    doGoal();
    checkOutput("score_saturates", int'(score), 255);
    idleCycles(8);

    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("pre_reset_dead", int'(state), 2);
    idleCycles(2);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_state", int'(state), 0);
    checkOutput("async_reset_lives", int'(lives), 3);
    checkOutput("async_reset_x", int'(x_pos), 10);
    checkOutput("async_reset_y", int'(y_pos), 14);
    checkOutput("async_reset_score", int'(score), 0);
    @(negedge clock);
    reset_n = 1'b1;
    idleCycles(1);
    checkOutput("post_reset_idle", int'(state), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
